// File: rtl/alu_cmp_iter_if.sv
// Handshake and result bundle for the iterative magnitude comparator.
// The master side drives operands and the result acknowledge; the slave
// side is the comparator itself.
interface alu_cmp_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       flags;
  logic [WIDTH-1:0] slt;

  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, out_valid, flags, slt
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, out_valid, flags, slt
  );
endinterface

// File: rtl/alu_cmp_iter.sv
// Multi-cycle magnitude comparator: scans two latched operands MSB-first,
// STEP bits per cycle, and reports one-hot {lt, gt, eq} plus an SLT word.
// Signed compares are turned into unsigned ones by flipping both MSBs at
// accept time (offset binary), so the scan logic never sees a sign.
module alu_cmp_iter #(
  parameter int WIDTH      = 32,
  parameter int STEP       = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic          clk,
  input logic          rst,
  alu_cmp_iter_if.slave bus
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             eq_q, eq_d;     // no differing chunk seen yet
  logic             gt_q, gt_d;     // frozen decision once eq_q drops
  logic [2:0]       flags_q, flags_d;

  logic             in_ready;
  logic             out_valid;
  logic             accept;
  logic [STEP-1:0]  chunk_a;
  logic [STEP-1:0]  chunk_b;
  logic             diff;
  logic             chunk_gt;
  logic             last_chunk;
  logic             finish;

  // The operands shift left each RUN cycle, so the current chunk is
  // always the top STEP bits of the working copies.
  assign chunk_a    = a_q[WIDTH-1 -: STEP];
  assign chunk_b    = b_q[WIDTH-1 -: STEP];
  assign diff       = (chunk_a != chunk_b);
  assign chunk_gt   = (chunk_a > chunk_b);
  assign last_chunk = (cnt_q == CNT_W'(N - 1));
  assign accept     = bus.in_valid && in_ready;
  assign finish     = (state_q == RUN) && (last_chunk || (EARLY_EXIT && diff));

  // State register with synchronous reset; reset overrides any handshake.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, scan in RUN, wait for ack in DONE.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_d
    // unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)        state_d = RUN;
      RUN:     if (finish)        state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next values: latch on accept, scan one chunk per RUN cycle,
  // publish flags only on the RUN->DONE transition.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    flags_d = flags_q;
    if (accept) begin
      a_d   = {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
      b_d   = {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
      cnt_d = '0;
      eq_d  = 1'b1;
      gt_d  = 1'b0;
    end else if (state_q == RUN) begin
      a_d   = a_q << STEP;
      b_d   = b_q << STEP;
      cnt_d = cnt_q + CNT_W'(1);
      eq_d  = eq_q & ~diff;
      gt_d  = eq_q ? (diff & chunk_gt) : gt_q;
      if (finish) begin
        flags_d = eq_d ? 3'b001 : (gt_d ? 3'b010 : 3'b100);
      end
    end
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the operand copies are reset too, even though they are
      // reloaded on every accept, so an aborted compare leaves no residue.
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      flags_q <= 3'b000;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      flags_q <= flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.flags     = flags_q;
  assign bus.slt       = {{(WIDTH-1){1'b0}}, flags_q[2]};

endmodule

// File: tb/tb_alu_cmp_iter.sv
// Directed bench for alu_cmp_iter. Four instances: 32-bit STEP=4 with and
// without early exit (driven in lockstep), and 8-bit STEP=1 (early exit)
// alongside 8-bit STEP=8 (constant latency), also driven in lockstep.
module tb_alu_cmp_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  alu_cmp_iter_if #(.WIDTH(32)) if32e ();
  alu_cmp_iter_if #(.WIDTH(32)) if32c ();
  alu_cmp_iter_if #(.WIDTH(8))  if8a ();
  alu_cmp_iter_if #(.WIDTH(8))  if8b ();

  logic        v32, sm32, or32;
  logic [31:0] a32, b32;
  logic        v8, sm8, or8;
  logic [7:0]  a8, b8;

  assign if32e.in_valid = v32;  assign if32c.in_valid = v32;
  assign if32e.a = a32;         assign if32c.a = a32;
  assign if32e.b = b32;         assign if32c.b = b32;
  assign if32e.signed_mode = sm32; assign if32c.signed_mode = sm32;
  assign if32e.out_ready = or32;   assign if32c.out_ready = or32;

  assign if8a.in_valid = v8;    assign if8b.in_valid = v8;
  assign if8a.a = a8;           assign if8b.a = a8;
  assign if8a.b = b8;           assign if8b.b = b8;
  assign if8a.signed_mode = sm8;   assign if8b.signed_mode = sm8;
  assign if8a.out_ready = or8;     assign if8b.out_ready = or8;

  alu_cmp_iter #(.WIDTH(32), .STEP(4), .EARLY_EXIT(1'b1)) u32e (.clk(clk), .rst(rst), .bus(if32e));
  alu_cmp_iter #(.WIDTH(32), .STEP(4), .EARLY_EXIT(1'b0)) u32c (.clk(clk), .rst(rst), .bus(if32c));
  alu_cmp_iter #(.WIDTH(8),  .STEP(1), .EARLY_EXIT(1'b1)) u8a  (.clk(clk), .rst(rst), .bus(if8a));
  alu_cmp_iter #(.WIDTH(8),  .STEP(8), .EARLY_EXIT(1'b0)) u8b  (.clk(clk), .rst(rst), .bus(if8b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // One 32-bit compare on both 32-bit instances; the constant-latency one
  // always needs 9 cycles. hold = extra DONE cycles with out_ready low.
  task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic sm, input logic [2:0] exp_f, input int lat_e_exp,
                       input int hold);
    int cyc, lat_e, lat_c;
    check({tag, " ready"}, {if32e.in_ready, if32c.in_ready}, 2'b11);
    v32 = 1'b1; a32 = a; b32 = b; sm32 = sm;
    @(posedge clk); #1;
    v32 = 1'b0; a32 = ~a; b32 = a; sm32 = ~sm;
    check({tag, " busy"}, {if32e.in_ready, if32c.in_ready}, 2'b00);
    cyc = 1; lat_e = 0; lat_c = 0;
    while ((lat_e == 0 || lat_c == 0) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (lat_e == 0 && if32e.out_valid) lat_e = cyc;
      if (lat_c == 0 && if32c.out_valid) lat_c = cyc;
    end
    check({tag, " lat_ee"}, lat_e, lat_e_exp);
    check({tag, " lat_const"}, lat_c, 9);
    check({tag, " flags_ee"}, if32e.flags, exp_f);
    check({tag, " flags_const"}, if32c.flags, exp_f);
    check({tag, " slt_ee"}, if32e.slt, {31'b0, exp_f[2]});
    check({tag, " slt_const"}, if32c.slt, {31'b0, exp_f[2]});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold"}, {if32e.out_valid, if32e.in_ready, if32e.flags,
                             if32c.out_valid, if32c.in_ready, if32c.flags},
            {1'b1, 1'b0, exp_f, 1'b1, 1'b0, exp_f});
    end
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    check({tag, " release"}, {if32e.in_ready, if32c.in_ready, if32e.out_valid, if32c.out_valid},
          4'b1100);
  endtask

  // One 8-bit compare on the STEP=1 (early exit) and STEP=8 instances.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sm, input logic [2:0] exp_f, input int lat_a_exp);
    int cyc, lat_a, lat_b;
    check({tag, " ready"}, {if8a.in_ready, if8b.in_ready}, 2'b11);
    v8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = b; b8 = ~b; sm8 = ~sm;
    cyc = 1; lat_a = 0; lat_b = 0;
    while ((lat_a == 0 || lat_b == 0) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (lat_a == 0 && if8a.out_valid) lat_a = cyc;
      if (lat_b == 0 && if8b.out_valid) lat_b = cyc;
    end
    check({tag, " lat_step1"}, lat_a, lat_a_exp);
    check({tag, " lat_step8"}, lat_b, 2);
    check({tag, " flags_step1"}, if8a.flags, exp_f);
    check({tag, " flags_step8"}, if8b.flags, exp_f);
    check({tag, " slt_step1"}, if8a.slt, {7'b0, exp_f[2]});
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    check({tag, " release"}, {if8a.in_ready, if8b.in_ready}, 2'b11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    v32 = 1'b0; sm32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
    v8  = 1'b0; sm8  = 1'b0; or8  = 1'b0; a8  = '0; b8  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset 32ee",  {if32e.in_ready, if32e.out_valid, if32e.flags, if32e.slt}, {1'b1, 1'b0, 3'b000, 32'h0});
    check("reset 32c",   {if32c.in_ready, if32c.out_valid, if32c.flags, if32c.slt}, {1'b1, 1'b0, 3'b000, 32'h0});
    check("reset 8s1",   {if8a.in_ready, if8a.out_valid, if8a.flags, if8a.slt}, {1'b1, 1'b0, 3'b000, 8'h0});
    check("reset 8s8",   {if8b.in_ready, if8b.out_valid, if8b.flags, if8b.slt}, {1'b1, 1'b0, 3'b000, 8'h0});

    // tag, a, b, signed, flags{lt,gt,eq}, early-exit latency, hold
    run32("eq_bp",     32'h1234_5678, 32'h1234_5678, 1'b0, 3'b001, 9, 5);
    run32("neg1_s",    32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, 2, 0);
    run32("neg1_u",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b010, 2, 0);
    run32("msb_u",     32'h8000_0000, 32'h0000_0000, 1'b0, 3'b010, 2, 0);
    run32("freeze_u",  32'h1234_0000, 32'h1230_FFFF, 1'b0, 3'b010, 5, 0);
    run32("last_u",    32'h1234_5678, 32'h1234_5679, 1'b0, 3'b100, 9, 0);
    run32("min_s",     32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b100, 2, 0);
    run32("neg_s",     32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 3'b100, 9, 0);
    run32("eqmin_s",   32'h8000_0000, 32'h8000_0000, 1'b1, 3'b001, 9, 0);

    // Abort a compare in its third RUN cycle; flags were 001 beforehand.
    v32 = 1'b1; a32 = 32'h1234_5678; b32 = 32'h1234_5678; sm32 = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("abort in_run", {if32e.in_ready, if32c.in_ready}, 2'b00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort 32ee", {if32e.in_ready, if32e.out_valid, if32e.flags, if32e.slt}, {1'b1, 1'b0, 3'b000, 32'h0});
    check("abort 32c",  {if32c.in_ready, if32c.out_valid, if32c.flags, if32c.slt}, {1'b1, 1'b0, 3'b000, 32'h0});
    run32("post_abort", 32'h0000_0005, 32'h0000_0007, 1'b1, 3'b100, 9, 0);

    // 8-bit sweep: STEP=1 latency = first differing bit position (from MSB) + 1.
    run8("eq8_u",   8'h3C, 8'h3C, 1'b0, 3'b001, 9);
    run8("msb8_u",  8'h80, 8'h7F, 1'b0, 3'b010, 2);
    run8("msb8_s",  8'h80, 8'h7F, 1'b1, 3'b100, 2);
    run8("lsb8_u",  8'h55, 8'h54, 1'b0, 3'b010, 9);
    run8("neg8_s",  8'hF0, 8'hF8, 1'b1, 3'b100, 6);
    run8("mid8_u",  8'h0A, 8'h0C, 1'b0, 3'b100, 7);
    run8("pm8_s",   8'h01, 8'hFF, 1'b1, 3'b010, 2);
    run8("eqmin8_s",8'h80, 8'h80, 1'b1, 3'b001, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmp_iter.md
# alu_cmp_iter

Parametrised, multi-cycle magnitude comparator for the ALU's set-less-than path. It takes two WIDTH-bit operands through a valid/ready handshake and scans them MSB-first, STEP bits per cycle, with optional early exit. It returns registered one-hot {lt, gt, eq} flags and a WIDTH-bit SLT word. Signed or unsigned comparison is selected per transaction; this replaces the fixed 32-bit combinational comparator with a throttleable unit for narrow-area or long-operand builds.

## Interface
- WIDTH, 32: operand width; WIDTH >= 2.
- STEP, 4: bits compared per cycle; 1 <= STEP <= WIDTH, WIDTH % STEP == 0; N = WIDTH/STEP.
- EARLY_EXIT, 1: 1 = finish on first differing chunk; 0 = always run N chunks (constant latency).
- Clock and reset (already decided): one clock, `clk`; reset `rst` is synchronous, active-high.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operands/mode valid.
- in_ready  out  1  high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- flags  out  3  flags[0]=eq, flags[1]=gt (a>b), flags[2]=lt (a<b); exactly one set when out_valid.
- slt  out  WIDTH  {WIDTH-1 zeros, lt}.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready, latch a, b and signed_mode, clear the chunk counter and set the eq tracker. Next state is RUN.
- Signed mode: invert the MSB of both latched operands (offset-binary). The compare is then unsigned. This makes -1 < 1 and 0x8000_0000 the minimum.
- RUN, cycle k (k = 1..N): compare chunk bits [WIDTH-1-(k-1)*STEP -: STEP] of the latched operands.
  - If the chunks are equal and k < N, increment the counter and stay in RUN.
  - If the chunks are equal and k = N, set the result to eq and go to DONE.
  - If the chunks differ, set gt or lt from the chunk compare and record the decision.
  - With EARLY_EXIT=1, a differing chunk sends the block to DONE immediately.
  - With EARLY_EXIT=0, the first decision is frozen. Later chunks are ignored and the block goes to DONE after chunk N.
- flags/slt are registered and written on the RUN→DONE transition. They hold their value until the next RUN→DONE transition.
- DONE: out_valid=1 and outputs are stable. On out_ready, go to IDLE next cycle. If out_ready stays low, hold indefinitely.
- No new operand is accepted in RUN or DONE (in_ready=0). The block never pipelines two transactions.
- Counter width: clog2(N+1) bits; no wrap is possible.

## Timing
- Reset: state=IDLE, in_ready=1, out_valid=0, flags=3'b000, slt=0, counter=0, latched operands=0.
- rst wins over every other event in the same cycle.
- Reset during RUN or DONE aborts the transaction. No out_valid is produced and outputs go to their reset values.
- Handshake accepted at edge E0. Chunk k is evaluated in the cycle after edge E(k-1).
- Latency with EARLY_EXIT=0: out_valid rises N+1 cycles after the in-handshake cycle.
- Latency with EARLY_EXIT=1: out_valid rises k+1 cycles after the handshake, where k is the first differing chunk (N if the operands are equal).
- Throughput: minimum 1 (IDLE) + N or k (RUN) + 1 (DONE) cycles per compare. The next in_ready comes the cycle after the out-handshake.
- in_valid/a/b may change freely outside the accept cycle; only values present at the accept edge are used.
- out_valid does not depend combinationally on out_ready. in_ready does not depend combinationally on in_valid.

## Test plan
- Equal operands: WIDTH=32, STEP=4, a=b=0x1234_5678 -> flags=001, slt=0, out_valid 9 cycles after the handshake (either EARLY_EXIT).
- Signed vs unsigned: a=0xFFFF_FFFF, b=0x0000_0001 -> signed_mode=1 gives flags=100, slt=1; signed_mode=0 gives flags=010, slt=0.
- Early exit: EARLY_EXIT=1, unsigned, a=0x8000_0000, b=0 -> flags=010, out_valid 2 cycles after the handshake; the same stimulus with EARLY_EXIT=0 gives out_valid at 9 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and flags stable and in_ready=0 throughout; after out_ready, in_ready=1 on the next cycle and a back-to-back compare is accepted.
- Reset mid-RUN: assert rst in RUN cycle 3 -> next cycle in_ready=1, out_valid=0, flags=000; a subsequent compare of 5 vs 7 yields lt.
- Parameter sweep: STEP=1 and STEP=WIDTH with WIDTH=8 on random signed/unsigned pairs -> flags match a reference compare and latencies match the formulas (N=8 and N=1).
